decomp_wr_arbiter: RTL and testbench
====================================

// Module: decomp_wr_arbiter
// PURPOSE
//  Shares one memory write port between the N_REQ byte-stream decompressors
//  (A, B, U, rest) fed by the IO FSM. Each decompressor presents decompressed
//  elements on a valid/grant handshake. The block:
//  - grants round-robin;
//  - generates per-object write addresses as base + running offset;
//  - tracks end-of-object per requester;
//  - pulses irq to the coordinator once every enabled object is fully written.
// PARAMETERS
//  N_REQ   4   number of decompressor requesters
//  DATA_W  32  decompressed element width
//  ADDR_W  16  memory address width
// PORTS
//  clk         in   1             system clock, all state on rising edge
//  reset       in   1             asynchronous, active-low reset
//  start       in   1             coordinator pulse: begin load phase (IDLE only)
//  enable_mask in   N_REQ         requesters taking part; sampled on accepted start
//  base_addr   in   N_REQ*ADDR_W  per-requester base, slice i = [i*ADDR_W +: ADDR_W]; sampled on start
//  req         in   N_REQ         requester i holds a valid element
//  req_data    in   N_REQ*DATA_W  element data, slice i
//  req_last    in   N_REQ         element on req_data[i] is the object's last
//  gnt         out  N_REQ         one-hot; element i captured at this rising edge
//  mem_we      out  1             write valid
//  mem_addr    out  ADDR_W        write address
//  mem_wdata   out  DATA_W        write data
//  mem_ready   in   1             memory accepts the write this cycle
//  done_mask   out  N_REQ         requester i has delivered its last element
//  busy        out  1             state != IDLE
//  irq         out  1             one-cycle pulse: all enabled objects written
// BEHAVIOUR
//  - reset low: state IDLE; gnt, mem_we, irq, busy = 0; mem_addr, mem_wdata,
//    done_mask, offsets = 0; rr pointer = 0. Assert/deassert is legal at any
//    time, including mid-operation. Any in-flight write is dropped, with no
//    retry.
//  - FSM:
//    - IDLE -> RUN on start. At that edge: latch base_addr; clear offsets;
//      done_mask <= ~enable_mask; rr pointer <= 0.
//    - RUN -> DRAIN when done_mask becomes all ones.
//    - DRAIN -> IDLE when !mem_we, or when mem_we & mem_ready. irq = 1 on that
//      transition edge's following cycle (exactly one cycle).
//    - enable_mask == 0: RUN -> DRAIN -> IDLE with no writes; irq two cycles
//      after start.
//    - start outside IDLE is ignored.
//  - slot_free = !mem_we | mem_ready (combinational).
//  - gnt is combinational and is nonzero only in RUN, when slot_free, and for
//    requesters with req & !done_mask. It picks exactly one, round-robin:
//    search starts at pointer, ascending, with wrap.
//  - On a grant to i:
//    - at the same edge: mem_wdata <= req_data[i];
//      mem_addr <= base[i] + offset[i] (mod 2^ADDR_W);
//      offset[i] <= offset[i] + 1 (wraps silently);
//      rr pointer <= (i+1) mod N_REQ.
//    - if req_last[i]: done_mask[i] <= 1 and requester i is excluded from
//      further grants.
//  - mem_we rises the cycle after the grant (latency 1). mem_we/mem_addr/
//    mem_wdata stay stable until mem_ready. A new grant may land in the same
//    cycle mem_ready retires the old write, giving one write per cycle at full
//    throughput.
//  - Requester protocol:
//    - a requester may assert req in any cycle;
//    - req_data and req_last must be stable while req & !gnt;
//    - after gnt, the requester presents its next element or drops req.
//  - req while IDLE or DRAIN, or req from a done requester, is ignored.
//  - Several req_last in one cycle: only the granted requester completes;
//    the others wait for their turn.
// STRUCTURE
//  - io_pkg: state localparams (IDLE=2'b00, RUN=2'b01, DRAIN=2'b10) and
//    defaults for N_REQ, DATA_W, ADDR_W.
//  - Sub-module rr_arbiter #(N): ports req, en, pointer; outputs one-hot gnt
//    and the grant index. Purely combinational; the pointer register lives in
//    the parent.
//  - Offset increment and address add use the existing adder module.
// TESTING
//  - Single requester: enable=0001, base0=0x100, three elements D0..D2, the
//    last with req_last -> writes to 0x100..0x102 in order; done_mask=0001;
//    irq pulses once.
//  - Fairness: all four req held high, mem_ready=1 -> gnt sequence
//    0001,0010,0100,1000,0001...; one write per cycle.
//  - Backpressure: mem_ready=0 for 5 cycles -> mem_we/addr/wdata held; gnt=0
//    throughout; no element lost or duplicated.
//  - Wrap: base=0xFFFE, four elements -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
//  - Simultaneous last: req0/req1 both assert req_last together -> granted in
//    rr order; irq only after the second write is accepted.
//  - Async reset mid-RUN with mem_we=1 -> all outputs 0 immediately. A new
//    start then re-latches bases; offsets restart at 0.

Source files
------------

// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the decompressor write-port arbiter:
//   - default sizing for requester count, element width and address width
//   - FSM state encoding (IDLE / RUN / DRAIN)
//   - idx_w(): width of an index into N items (at least 1 bit)
// -----------------------------------------------------------------------------
package io_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
// Plain W-bit modular adder; carry out is discarded so sums wrap silently.
//   a, b : operands
//   s    : (a + b) mod 2^W
// -----------------------------------------------------------------------------
module adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s
);

    assign s = a + b;

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The candidate set is req & en; the search
// starts at 'pointer' and walks upward with wrap. The pointer register is owned
// by the parent, which advances it past the winner.
//   req     : request vector
//   en      : per-requester enable (already gated by the parent)
//   pointer : first index to consider
//   gnt     : one-hot winner, zero when nobody is eligible
//   idx     : binary index of the winner (0 when gnt is zero)
// -----------------------------------------------------------------------------
module rr_arbiter
    import io_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  en,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [N-1:0]  elig;
    logic [IW-1:0] j;
    logic          found;

    assign elig = req & en;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(pointer) + k) % N);
            if (!found && elig[j]) begin
                gnt[j] = 1'b1;
                idx    = j;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decomp_wr_arbiter.sv
// -----------------------------------------------------------------------------
// decomp_wr_arbiter
// Shares one memory write port between N_REQ decompressor streams. Grants are
// round-robin; each requester writes to base[i] + offset[i], the offset
// advancing per accepted element. When every enabled requester has delivered
// its last element and the final write has been accepted, irq pulses once.
//
// Ports
//   clk, reset              clock; asynchronous active-low reset
//   start                   begin a load phase (accepted in IDLE only)
//   enable_mask             requesters taking part, sampled on start
//   base_addr               per-requester base, slice i, sampled on start
//   req/req_data/req_last   per-requester element handshake inputs
//   gnt                     one-hot grant (combinational)
//   mem_we/addr/wdata       registered write request, held until mem_ready
//   mem_ready               memory accepts the current write
//   done_mask               requester delivered its last element (or disabled)
//   busy                    FSM not in IDLE
//   irq                     one-cycle completion pulse
// -----------------------------------------------------------------------------
module decomp_wr_arbiter
    import io_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N_REQ-1:0]          enable_mask,
    input  logic [N_REQ*ADDR_W-1:0]   base_addr,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          gnt,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    output logic [N_REQ-1:0]          done_mask,
    output logic                      busy,
    output logic                      irq
);

    localparam int IW = idx_w(N_REQ);

    state_e                          state_q, state_d;
    logic [N_REQ-1:0][ADDR_W-1:0]    base_q, base_d;
    logic [N_REQ-1:0][ADDR_W-1:0]    off_q, off_d;
    logic [N_REQ-1:0]                done_q, done_d;
    logic [IW-1:0]                   ptr_q, ptr_d;
    logic                            mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]               mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]               mem_wdata_q, mem_wdata_d;
    logic                            irq_q, irq_d;

    logic [N_REQ-1:0][ADDR_W-1:0]    base_in;
    logic [N_REQ-1:0][DATA_W-1:0]    data_in;
    logic [N_REQ-1:0][ADDR_W-1:0]    off_inc;
    logic [N_REQ-1:0][ADDR_W-1:0]    addr_sum;
    logic [N_REQ-1:0]                arb_en;
    logic [IW-1:0]                   gnt_idx;
    logic                            gnt_any;
    logic                            slot_free;

    assign base_in = base_addr;
    assign data_in = req_data;

    // Per-requester address generation: next offset and current write address.
    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        adder #(.W(ADDR_W)) u_inc (
            .a (off_q[i]),
            .b (ADDR_W'(1)),
            .s (off_inc[i])
        );
        adder #(.W(ADDR_W)) u_addr (
            .a (base_q[i]),
            .b (off_q[i]),
            .s (addr_sum[i])
        );
    end

    // The output register can take a new element when empty or retiring now.
    assign slot_free = !mem_we_q || mem_ready;
    assign arb_en    = ~done_q & {N_REQ{(state_q == RUN) && slot_free}};

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req     (req),
        .en      (arb_en),
        .pointer (ptr_q),
        .gnt     (gnt),
        .idx     (gnt_idx)
    );

    assign gnt_any = |gnt;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        off_d       = off_q;
        done_d      = done_q;
        ptr_d       = ptr_q;
        mem_we_d    = mem_we_q && !mem_ready;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        irq_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    base_d  = base_in;
                    off_d   = '0;
                    // Disabled requesters count as already finished.
                    done_d  = ~enable_mask;
                    ptr_d   = '0;
                end
            end
            RUN: begin
                if (&done_q) state_d = DRAIN;
            end
            DRAIN: begin
                // Wait for the final write to leave before signalling.
                if (!mem_we_q || mem_ready) begin
                    state_d = IDLE;
                    irq_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (gnt_any) begin
            mem_we_d         = 1'b1;
            mem_addr_d       = addr_sum[gnt_idx];
            mem_wdata_d      = data_in[gnt_idx];
            off_d[gnt_idx]   = off_inc[gnt_idx];
            ptr_d            = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (req_last[gnt_idx]) done_d[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            off_q       <= '0;
            done_q      <= '0;
            ptr_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            off_q       <= off_d;
            done_q      <= done_d;
            ptr_q       <= ptr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            irq_q       <= irq_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done_mask = done_q;
    assign busy      = (state_q != IDLE);
    assign irq       = irq_q;

endmodule

// File: tb/tb_decomp_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_decomp_wr_arbiter
// Directed vectors for the write-port arbiter. Each table row drives one
// cycle's inputs at the falling edge and states what the outputs must be
// before the next rising edge. Requester i presents data {i, 8'h00, count}
// where count advances each time that requester is granted, so the expected
// write data identifies exactly which element of which stream was written.
// -----------------------------------------------------------------------------
module tb_decomp_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [N-1:0]       enable_mask = '0;
    logic [N-1:0][AW-1:0] bs = '0;
    logic [N-1:0][DW-1:0] rd = '0;
    logic [N-1:0]       req = '0;
    logic [N-1:0]       req_last = '0;
    logic               mem_ready = 1'b1;
    logic [N-1:0]       gnt;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [N-1:0]       done_mask;
    logic               busy;
    logic               irq;
    logic [N*AW-1:0]    base_flat;
    logic [N*DW-1:0]    data_flat;

    assign base_flat = bs;
    assign data_flat = rd;

    always #5 clk = ~clk;

    decomp_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .enable_mask (enable_mask),
        .base_addr   (base_flat),
        .req         (req),
        .req_data    (data_flat),
        .req_last    (req_last),
        .gnt         (gnt),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .done_mask   (done_mask),
        .busy        (busy),
        .irq         (irq)
    );

    typedef struct {
        logic          st;
        logic [3:0]    msk;
        logic [3:0]    rq;
        logic [3:0]    ls;
        logic          rdy;
        logic [3:0]    g;
        logic          we;
        logic [15:0]   a;
        logic [31:0]   d;
        logic [3:0]    dn;
        logic          by;
        logic          iq;
    } vec_t;

    vec_t       vq[$];
    int         total = 0;
    int         bad = 0;
    int         row = 0;
    int         cnt[N];
    logic [N-1:0] prev_g = '0;

    function automatic vec_t mk(input logic st, input logic [3:0] msk,
                                input logic [3:0] rq, input logic [3:0] ls,
                                input logic rdy, input logic [3:0] g,
                                input logic we, input logic [15:0] a,
                                input logic [31:0] d, input logic [3:0] dn,
                                input logic by, input logic iq);
        vec_t v;
        v.st = st; v.msk = msk; v.rq = rq; v.ls = ls; v.rdy = rdy;
        v.g = g; v.we = we; v.a = a; v.d = d; v.dn = dn; v.by = by; v.iq = iq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
        end
    endtask

    task automatic run_rows();
        for (int k = 0; k < vq.size(); k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (prev_g[i]) cnt[i]++;
            if (vq[k].st) for (int i = 0; i < N; i++) cnt[i] = 0;
            for (int i = 0; i < N; i++) rd[i] = {8'(i), 8'h00, 16'(cnt[i])};
            start       = vq[k].st;
            enable_mask = vq[k].msk;
            req         = vq[k].rq;
            req_last    = vq[k].ls;
            mem_ready   = vq[k].rdy;
            #1;
            chk("gnt", 32'(gnt), 32'(vq[k].g));
            chk("mem_we", 32'(mem_we), 32'(vq[k].we));
            if (vq[k].we) begin
                chk("mem_addr", 32'(mem_addr), 32'(vq[k].a));
                chk("mem_wdata", mem_wdata, vq[k].d);
            end
            chk("done_mask", 32'(done_mask), 32'(vq[k].dn));
            chk("busy", 32'(busy), 32'(vq[k].by));
            chk("irq", 32'(irq), 32'(vq[k].iq));
            prev_g = gnt;
            row++;
        end
        vq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) cnt[i] = 0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_done", 32'(done_mask), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        reset = 1'b1;

        // Single requester, three elements, last on the third.
        bs[0] = 16'h0100;
        vq.push_back(mk(1, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b0000, 0, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 1, 4'b0001, 0, 16'h0, 32'h0, 4'b1110, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 1, 4'b0001, 1, 16'h0100, 32'h0, 4'b1110, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0001, 4'b0001, 1, 4'b0001, 1, 16'h0101, 32'h1, 4'b1110, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0001, 4'b0001, 1, 4'b0000, 1, 16'h0102, 32'h2, 4'b1111, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 0, 1));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 0, 0));
        run_rows();

        // Fairness with a 5-cycle backpressure window, then staggered lasts.
        bs[0] = 16'h0100; bs[1] = 16'h0200; bs[2] = 16'h0300; bs[3] = 16'h0400;
        vq.push_back(mk(1, 4'b1111, 4'b1111, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 0, 0));
        vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 1, 4'b0001, 0, 16'h0, 32'h0, 4'b0000, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 1, 4'b0010, 1, 16'h0100, 32'h00000000, 4'b0000, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 1, 4'b0100, 1, 16'h0200, 32'h01000000, 4'b0000, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 1, 4'b1000, 1, 16'h0300, 32'h02000000, 4'b0000, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 1, 4'b0001, 1, 16'h0400, 32'h03000000, 4'b0000, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 1, 4'b0010, 1, 16'h0101, 32'h00000001, 4'b0000, 1, 0));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 0, 4'b0000, 1, 16'h0201, 32'h01000001, 4'b0000, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 1, 4'b0100, 1, 16'h0201, 32'h01000001, 4'b0000, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b0000, 1, 4'b1000, 1, 16'h0301, 32'h02000001, 4'b0000, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 1, 4'b0001, 1, 16'h0401, 32'h03000001, 4'b0000, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 1, 4'b0010, 1, 16'h0102, 32'h00000002, 4'b0001, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 1, 4'b0100, 1, 16'h0202, 32'h01000002, 4'b0011, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 1, 4'b1000, 1, 16'h0302, 32'h02000002, 4'b0111, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 1, 4'b0000, 1, 16'h0402, 32'h03000002, 4'b1111, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 0, 1));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 0, 0));
        run_rows();

        // Empty enable mask; requests from done requesters and late starts ignored.
        vq.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 0, 0));
        vq.push_back(mk(1, 4'b0001, 4'b1111, 4'b1111, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 1, 0));
        vq.push_back(mk(1, 4'b0001, 4'b1111, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 0, 1));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 0, 0));
        run_rows();

        // Address wrap past 0xFFFF.
        bs[0] = 16'hFFFE;
        vq.push_back(mk(1, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 0, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 1, 4'b0001, 0, 16'h0, 32'h0, 4'b1110, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 1, 4'b0001, 1, 16'hFFFE, 32'h0, 4'b1110, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0001, 4'b0000, 1, 4'b0001, 1, 16'hFFFF, 32'h1, 4'b1110, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0001, 4'b0001, 1, 4'b0001, 1, 16'h0000, 32'h2, 4'b1110, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 16'h0001, 32'h3, 4'b1111, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 0, 1));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 0, 0));
        run_rows();

        // Simultaneous last on 0 and 1 with a stalled memory; irq waits for
        // the second write to be accepted.
        bs[0] = 16'h0100; bs[1] = 16'h0200;
        vq.push_back(mk(1, 4'b0011, 4'b0011, 4'b0011, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 0, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0011, 4'b0011, 1, 4'b0001, 0, 16'h0, 32'h0, 4'b1100, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0010, 4'b0010, 0, 4'b0000, 1, 16'h0100, 32'h00000000, 4'b1101, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0010, 4'b0010, 1, 4'b0010, 1, 16'h0100, 32'h00000000, 4'b1101, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 1, 16'h0200, 32'h01000000, 4'b1111, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 1, 16'h0200, 32'h01000000, 4'b1111, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 16'h0200, 32'h01000000, 4'b1111, 1, 0));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 0, 1));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'h0, 32'h0, 4'b1111, 0, 0));
        run_rows();

        // Asynchronous reset in the middle of a held write, then a fresh start.
        @(negedge clk);
        bs[0] = 16'h0500; rd[0] = 32'hDEAD0000;
        start = 1'b1; enable_mask = 4'b0001; req = 4'b0001; req_last = 4'b0000; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1 chk("hr_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        #1;
        chk("hr_we", 32'(mem_we), 32'h1);
        chk("hr_addr", 32'(mem_addr), 32'h0500);
        #1 reset = 1'b0;
        #1;
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_we", 32'(mem_we), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_addr", 32'(mem_addr), 32'h0);
        chk("ar_wdata", mem_wdata, 32'h0);
        chk("ar_done", 32'(done_mask), 32'h0);
        chk("ar_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        bs[0] = 16'h0700; rd[0] = 32'hBEEF0000;
        start = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 chk("re_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        #1;
        chk("re_we", 32'(mem_we), 32'h1);
        chk("re_addr", 32'(mem_addr), 32'h0700);
        chk("re_wdata", mem_wdata, 32'hBEEF0000);
        req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
